// File: rtl/alu_operand_sequencer.sv
// Gathers NUM_OPERANDS words per ALU op, holds them on the ALU inputs, then returns the captured result.
// Latency: result valid ALU_LATENCY+1 cycles after the last operand handshake; one op in flight.
// Backpressure: in_ready drops outside COLLECT; the result is held until out_ready.
module alu_operand_sequencer #(
    parameter int DATA_WIDTH   = 32,
    parameter int FUNC_WIDTH   = 3,
    parameter int NUM_OPERANDS = 3,
    parameter int ALU_LATENCY  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [FUNC_WIDTH-1:0] in_func,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [FUNC_WIDTH-1:0] alu_func,
    output logic [DATA_WIDTH-1:0] alu_data_in1,
    output logic [DATA_WIDTH-1:0] alu_data_in2,
    output logic [DATA_WIDTH-1:0] alu_data_in3,
    input  logic [DATA_WIDTH-1:0] alu_data_out,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  illegal_func,
    output logic [15:0]           op_count
);

    localparam int IDX_W = 2;
    localparam int CNT_W = 3;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPERANDS - 1);
    localparam logic [CNT_W-1:0] EXEC_CNT = CNT_W'(ALU_LATENCY);

    typedef enum logic [1:0] {COLLECT, EXEC, RESULT} state_t;

    state_t                  state_q;
    logic [IDX_W-1:0]        idx_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [FUNC_WIDTH-1:0]   func_q;
    logic [DATA_WIDTH-1:0]   in1_q, in2_q, in3_q;
    logic [DATA_WIDTH-1:0]   out_data_q;
    logic                    out_valid_q;
    logic                    illegal_q;
    logic [15:0]             op_count_q;

    logic                    in_hs;
    logic                    last_word;
    logic [FUNC_WIDTH-1:0]   func_d;
    logic                    illegal_d;

    // With a single operand the function code arrives on the same edge as E0.
    always_comb begin
        in_hs     = in_valid & in_ready;
        last_word = (idx_q == LAST_IDX);
        func_d    = (idx_q == '0) ? in_func : func_q;
        illegal_d = in_hs & last_word & (32'(func_d) >= 32'd6);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= COLLECT;
            idx_q       <= '0;
            cnt_q       <= '0;
            func_q      <= '0;
            in1_q       <= '0;
            in2_q       <= '0;
            in3_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            op_count_q  <= '0;
        end else begin
            illegal_q <= 1'b0;
            case (state_q)
                COLLECT: begin
                    if (in_hs) begin
                        case (idx_q)
                            2'd0: begin
                                func_q <= in_func;
                                in1_q  <= in_data;
                            end
                            2'd1:    in2_q <= in_data;
                            default: in3_q <= in_data;
                        endcase
                        if (last_word) begin
                            idx_q <= '0;
                            if (illegal_d) begin
                                illegal_q <= 1'b1;
                            end else begin
                                state_q <= EXEC;
                                cnt_q   <= EXEC_CNT;
                            end
                        end else begin
                            idx_q <= idx_q + 2'd1;
                        end
                    end
                end
                EXEC: begin
                    if (cnt_q == '0) begin
                        out_data_q  <= alu_data_out;
                        out_valid_q <= 1'b1;
                        state_q     <= RESULT;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                RESULT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        op_count_q  <= op_count_q + 16'd1;
                        state_q     <= COLLECT;
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign in_ready     = (state_q == COLLECT) & ~rst;
    assign busy         = (state_q != COLLECT) | (idx_q != '0);
    assign alu_func     = func_q;
    assign alu_data_in1 = in1_q;
    assign alu_data_in2 = in2_q;
    assign alu_data_in3 = in3_q;
    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;
    assign illegal_func = illegal_q;
    assign op_count     = op_count_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench: dut0 uses a combinational ALU, dut3 a 3-stage ALU; sel picks the unit under stimulus.
module tb_alu_operand_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic [31:0] in_data = '0;
    logic [2:0]  in_func = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    logic        in_valid0, in_valid3;
    logic        in_ready0, in_ready3, out_valid0, out_valid3;
    logic        busy0, busy3, ill0, ill3;
    logic [2:0]  func0, func3;
    logic [31:0] a1_0, a2_0, a3_0, a1_3, a2_3, a3_3;
    logic [31:0] aout0, aout3, od0, od3;
    logic [15:0] cnt0, cnt3;
    logic [31:0] p0, p1, p2;

    assign in_valid0 = in_valid & ~sel;
    assign in_valid3 = in_valid & sel;
    assign aout0     = a1_0 + a2_0;
    always @(posedge clk) begin
        p0 <= a1_3 + a2_3;
        p1 <= p0;
        p2 <= p1;
    end
    assign aout3 = p2;

    alu_operand_sequencer #(.DATA_WIDTH(32), .FUNC_WIDTH(3), .NUM_OPERANDS(3), .ALU_LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_func(in_func), .in_valid(in_valid0),
        .in_ready(in_ready0), .alu_func(func0), .alu_data_in1(a1_0), .alu_data_in2(a2_0),
        .alu_data_in3(a3_0), .alu_data_out(aout0), .out_data(od0), .out_valid(out_valid0),
        .out_ready(out_ready), .busy(busy0), .illegal_func(ill0), .op_count(cnt0));

    alu_operand_sequencer #(.DATA_WIDTH(32), .FUNC_WIDTH(3), .NUM_OPERANDS(3), .ALU_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_func(in_func), .in_valid(in_valid3),
        .in_ready(in_ready3), .alu_func(func3), .alu_data_in1(a1_3), .alu_data_in2(a2_3),
        .alu_data_in3(a3_3), .alu_data_out(aout3), .out_data(od3), .out_valid(out_valid3),
        .out_ready(out_ready), .busy(busy3), .illegal_func(ill3), .op_count(cnt3));

    wire        m_in_ready  = sel ? in_ready3  : in_ready0;
    wire        m_out_valid = sel ? out_valid3 : out_valid0;
    wire [31:0] m_out_data  = sel ? od3        : od0;
    wire        m_busy      = sel ? busy3      : busy0;
    wire        m_ill       = sel ? ill3       : ill0;
    wire [15:0] m_cnt       = sel ? cnt3       : cnt0;
    wire [2:0]  m_func      = sel ? func3      : func0;
    wire [31:0] m_a1        = sel ? a1_3       : a1_0;
    wire [31:0] m_a2        = sel ? a2_3       : a2_0;
    wire [31:0] m_a3        = sel ? a3_3       : a3_0;

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic send_word(input logic [31:0] d, input logic [2:0] f);
        int n = 0;
        in_data  = d;
        in_func  = f;
        in_valid = 1'b1;
        while (!m_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin errors++; $display("FAIL send_word_timeout: in_ready got 0 for 50 cycles, required 1"); end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++; if (in_ready0 !== 1'b0)  begin errors++; $display("FAIL rst_in_ready got %0b exp 0", in_ready0); end
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b exp 0", out_valid0); end
        checks++; if (busy0 !== 1'b0)      begin errors++; $display("FAIL rst_busy got %0b exp 0", busy0); end
        checks++; if (cnt0 !== 16'h0)      begin errors++; $display("FAIL rst_op_count got %0h exp 0", cnt0); end
        checks++; if (od3 !== 32'h0)       begin errors++; $display("FAIL rst_out_data got %0h exp 0", od3); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (in_ready0 !== 1'b1)  begin errors++; $display("FAIL rst_release_in_ready got %0b exp 1", in_ready0); end
        checks++; if (in_ready3 !== 1'b1)  begin errors++; $display("FAIL rst_release_in_ready3 got %0b exp 1", in_ready3); end
        @(negedge clk);
    endtask

    task automatic test_basic_op();
        sel = 1'b0; out_ready = 1'b1;
        send_word(32'd5, 3'd0); send_word(32'd7, 3'd5); send_word(32'd9, 3'd5);
        checks++; if (m_a1 !== 32'd5 || m_a2 !== 32'd7 || m_a3 !== 32'd9) begin errors++; $display("FAIL basic_operands got %0d %0d %0d exp 5 7 9", m_a1, m_a2, m_a3); end
        checks++; if (m_func !== 3'd0)      begin errors++; $display("FAIL basic_func got %0d exp 0", m_func); end
        checks++; if (m_out_valid !== 1'b0 || m_in_ready !== 1'b0 || m_busy !== 1'b1) begin errors++; $display("FAIL basic_exec got v%0b r%0b b%0b exp v0 r0 b1", m_out_valid, m_in_ready, m_busy); end
        @(negedge clk);
        checks++; if (m_out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got %0b exp 1", m_out_valid); end
        checks++; if (m_out_data !== 32'd12) begin errors++; $display("FAIL basic_out_data got %0d exp 12", m_out_data); end
        @(negedge clk);
        checks++; if (m_out_valid !== 1'b0 || m_cnt !== 16'd1 || m_busy !== 1'b0) begin errors++; $display("FAIL basic_done got v%0b cnt%0d b%0b exp v0 cnt1 b0", m_out_valid, m_cnt, m_busy); end
    endtask

    task automatic test_latency3();
        sel = 1'b1; out_ready = 1'b1;
        send_word(32'd5, 3'd0); send_word(32'd7, 3'd0); send_word(32'd9, 3'd0);
        for (int k = 0; k < 3; k++) begin
            checks++; if (m_out_valid !== 1'b0 || m_in_ready !== 1'b0) begin errors++; $display("FAIL lat3_exec_%0d got v%0b r%0b exp v0 r0", k, m_out_valid, m_in_ready); end
            @(negedge clk);
        end
        checks++; if (m_out_valid !== 1'b0 || m_in_ready !== 1'b0) begin errors++; $display("FAIL lat3_exec_last got v%0b r%0b exp v0 r0", m_out_valid, m_in_ready); end
        @(negedge clk);
        checks++; if (m_out_valid !== 1'b1 || m_out_data !== 32'd12) begin errors++; $display("FAIL lat3_result got v%0b d%0d exp v1 d12", m_out_valid, m_out_data); end
        @(negedge clk);
        checks++; if (m_out_valid !== 1'b0 || m_cnt !== 16'd1) begin errors++; $display("FAIL lat3_done got v%0b cnt%0d exp v0 cnt1", m_out_valid, m_cnt); end
        sel = 1'b0;
    endtask

    task automatic test_backpressure();
        sel = 1'b0; out_ready = 1'b0;
        send_word(32'd10, 3'd1); send_word(32'd20, 3'd1); send_word(32'd30, 3'd1);
        in_data = 32'd99; in_func = 3'd0; in_valid = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            checks++; if (m_out_valid !== 1'b1 || m_out_data !== 32'd30 || m_in_ready !== 1'b0 || m_a1 !== 32'd10) begin
                errors++; $display("FAIL bp_hold_%0d got v%0b d%0d r%0b a1=%0d exp v1 d30 r0 a1=10", k, m_out_valid, m_out_data, m_in_ready, m_a1); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (m_out_valid !== 1'b0 || m_cnt !== 16'd2 || m_a1 !== 32'd10) begin errors++; $display("FAIL bp_release got v%0b cnt%0d a1=%0d exp v0 cnt2 a1=10", m_out_valid, m_cnt, m_a1); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (m_a1 !== 32'd99 || m_busy !== 1'b1) begin errors++; $display("FAIL bp_next_word got a1=%0d b%0b exp a1=99 b1", m_a1, m_busy); end
        send_word(32'd1, 3'd0); send_word(32'd2, 3'd0);
        @(negedge clk);
        checks++; if (m_out_valid !== 1'b1 || m_out_data !== 32'd100) begin errors++; $display("FAIL bp_next_result got v%0b d%0d exp v1 d100", m_out_valid, m_out_data); end
        @(negedge clk);
        checks++; if (m_cnt !== 16'd3) begin errors++; $display("FAIL bp_count got %0d exp 3", m_cnt); end
    endtask

    task automatic test_illegal_func();
        int pulses = 1;
        sel = 1'b0; out_ready = 1'b1;
        send_word(32'd1, 3'd6); send_word(32'd2, 3'd0); send_word(32'd3, 3'd0);
        checks++; if (m_ill !== 1'b1 || m_out_valid !== 1'b0 || m_in_ready !== 1'b1 || m_busy !== 1'b0) begin
            errors++; $display("FAIL ill_pulse got i%0b v%0b r%0b b%0b exp i1 v0 r1 b0", m_ill, m_out_valid, m_in_ready, m_busy); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (m_ill === 1'b1 || m_out_valid === 1'b1) pulses++;
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL ill_once got %0d pulses/valids exp 1", pulses); end
        checks++; if (m_cnt !== 16'd3) begin errors++; $display("FAIL ill_count got %0d exp 3", m_cnt); end
        send_word(32'd4, 3'd2); send_word(32'd5, 3'd0); send_word(32'd6, 3'd0);
        @(negedge clk);
        checks++; if (m_out_valid !== 1'b1 || m_out_data !== 32'd9 || m_func !== 3'd2) begin errors++; $display("FAIL ill_next got v%0b d%0d f%0d exp v1 d9 f2", m_out_valid, m_out_data, m_func); end
        @(negedge clk);
        checks++; if (m_cnt !== 16'd4) begin errors++; $display("FAIL ill_next_count got %0d exp 4", m_cnt); end
    endtask

    task automatic test_mid_reset();
        sel = 1'b0; out_ready = 1'b1;
        send_word(32'd11, 3'd1); send_word(32'd22, 3'd1);
        rst = 1'b1;
        #1;
        checks++; if (m_a1 !== 32'd0 || m_a2 !== 32'd0 || m_func !== 3'd0 || m_busy !== 1'b0 || m_in_ready !== 1'b0 || m_cnt !== 16'd0) begin
            errors++; $display("FAIL mrst_clear got a1=%0d a2=%0d f%0d b%0b r%0b cnt%0d exp all 0", m_a1, m_a2, m_func, m_busy, m_in_ready, m_cnt); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (m_in_ready !== 1'b1) begin errors++; $display("FAIL mrst_release got r%0b exp 1", m_in_ready); end
        @(negedge clk);
        send_word(32'd3, 3'd0); send_word(32'd4, 3'd0); send_word(32'd5, 3'd0);
        checks++; if (m_a1 !== 32'd3 || m_a2 !== 32'd4 || m_a3 !== 32'd5) begin errors++; $display("FAIL mrst_operands got %0d %0d %0d exp 3 4 5", m_a1, m_a2, m_a3); end
        @(negedge clk);
        checks++; if (m_out_valid !== 1'b1 || m_out_data !== 32'd7) begin errors++; $display("FAIL mrst_result got v%0b d%0d exp v1 d7", m_out_valid, m_out_data); end
        @(negedge clk);
        checks++; if (m_cnt !== 16'd1) begin errors++; $display("FAIL mrst_count got %0d exp 1", m_cnt); end
    endtask

    task automatic test_count_wrap();
        sel = 1'b0; out_ready = 1'b1;
        force dut0.op_count_q = 16'hFFFF;
        #1;
        release dut0.op_count_q;
        @(negedge clk);
        checks++; if (m_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload got %0h exp ffff", m_cnt); end
        send_word(32'd1, 3'd0); send_word(32'd1, 3'd0); send_word(32'd1, 3'd0);
        @(negedge clk);
        checks++; if (m_out_valid !== 1'b1 || m_out_data !== 32'd2) begin errors++; $display("FAIL wrap_result got v%0b d%0d exp v1 d2", m_out_valid, m_out_data); end
        @(negedge clk);
        checks++; if (m_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_count got %0h exp 0", m_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic_op();
        test_latency3();
        test_backpressure();
        test_illegal_func();
        test_mid_reset();
        test_count_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
